// File: rtl/activation_interp_scheduler_if.sv
// Request/result/configuration bundle of the shared activation interpolator.
// The master side is the requester/consumer/config world, the slave side is the scheduler.
interface activation_interp_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_data;
    logic [ID_W-1:0]           out_id;
    logic                      cfg_we;
    logic [3:0]                cfg_addr;
    logic [DATA_W-1:0]         cfg_data;
    logic                      cfg_ready;
    logic                      busy;

    modport master (
        output req_valid, req_data, out_ready, cfg_we, cfg_addr, cfg_data,
        input  req_ready, out_valid, out_data, out_id, cfg_ready, busy
    );

    modport slave (
        input  req_valid, req_data, out_ready, cfg_we, cfg_addr, cfg_data,
        output req_ready, out_valid, out_data, out_id, cfg_ready, busy
    );
endinterface

// File: rtl/activation_interp_scheduler.sv
// Round-robin shared piecewise-linear activation unit: one Q4.4 sample in flight,
// interpolated between two entries of a loadable 16-point breakpoint table.
module activation_interp_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int FRAC_W  = 4,
    parameter int ID_W    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    activation_interp_scheduler_if.slave  bus
);
    localparam int IDX_W  = DATA_W - FRAC_W;
    localparam int LUT_N  = 1 << IDX_W;
    localparam int PROD_W = DATA_W + FRAC_W + 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_CALC  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]        state_q,      state_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [ID_W-1:0]   out_id_q,     out_id_d;
    logic [DATA_W-1:0] x_q,          x_d;
    logic [DATA_W-1:0] base_q,       base_d;
    logic [DATA_W-1:0] next_q,       next_d;
    logic [DATA_W-1:0] out_data_q,   out_data_d;
    logic [DATA_W-1:0] lut_q [LUT_N];
    logic [DATA_W-1:0] lut_d [LUT_N];

    logic [NUM_REQ-1:0] grant_onehot;
    logic               grant_found;
    logic [ID_W-1:0]    grant_id;
    logic [DATA_W-1:0]  grant_x;
    logic [IDX_W-1:0]   idx, idx_next;
    logic signed [DATA_W:0]   diff;
    logic signed [PROD_W-1:0] diff_w, rem_w, prod;

    // Two passes give the rotating priority: first the requesters above last_grant, then wrap.
    always_comb begin
        grant_found  = 1'b0;
        grant_onehot = '0;
        grant_id     = '0;
        grant_x      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && bus.req_valid[i] && (i > int'(last_grant_q))) begin
                grant_found     = 1'b1;
                grant_onehot[i] = 1'b1;
                grant_id        = ID_W'(i);
                grant_x         = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && bus.req_valid[i] && (i <= int'(last_grant_q))) begin
                grant_found     = 1'b1;
                grant_onehot[i] = 1'b1;
                grant_id        = ID_W'(i);
                grant_x         = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Offset-binary index: adding half the table maps the signed integer part onto 0..15.
    always_comb begin
        idx      = x_q[DATA_W-1:FRAC_W] + IDX_W'(LUT_N / 2);
        idx_next = idx + 1'b1;
        diff     = {next_q[DATA_W-1], next_q} - {base_q[DATA_W-1], base_q};
        diff_w   = PROD_W'(diff);
        rem_w    = PROD_W'({1'b0, x_q[FRAC_W-1:0]});
        prod     = diff_w * rem_w;
    end

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        out_id_d      = out_id_q;
        x_d           = x_q;
        base_d        = base_q;
        next_d        = next_q;
        out_data_d    = out_data_q;
        lut_d         = lut_q;
        bus.req_ready = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.cfg_we) begin
                    lut_d[bus.cfg_addr] = bus.cfg_data;
                end else if (grant_found) begin
                    bus.req_ready = grant_onehot;
                    last_grant_d  = grant_id;
                    out_id_d      = grant_id;
                    x_d           = grant_x;
                    state_d       = S_FETCH;
                end
            end
            S_FETCH: begin
                base_d  = lut_q[idx];
                next_d  = (idx != '1) ? lut_q[idx_next] : lut_q[idx];
                state_d = S_CALC;
            end
            S_CALC: begin
                // The result lies between base and next, so modulo-2^8 addition is exact.
                out_data_d = base_q + DATA_W'(prod >>> FRAC_W);
                state_d    = S_OUT;
            end
            default: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: the breakpoint table is reset along with the control state, because a reset must leave it all-zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            out_id_q     <= '0;
            x_q          <= '0;
            base_q       <= '0;
            next_q       <= '0;
            out_data_q   <= '0;
            for (int i = 0; i < LUT_N; i++) lut_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            out_id_q     <= out_id_d;
            x_q          <= x_d;
            base_q       <= base_d;
            next_q       <= next_d;
            out_data_q   <= out_data_d;
            lut_q        <= lut_d;
        end
    end

    assign bus.out_valid = (state_q == S_OUT);
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;
    assign bus.cfg_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: doc/activation_interp_scheduler.md
# activation_interp_scheduler

Time-multiplexed activation-function unit for the fixed-point neural-network layers. NUM_REQ neuron requesters share one piecewise-linear interpolator: the scheduler arbitrates round-robin, splits each Q4.4 pre-activation into a table index and fractional remainder, fetches the two bracketing table points, interpolates and returns the tagged result. The 16-entry breakpoint table is loaded through a configuration port, so one unit serves sigmoid, tanh or any other activation shape.

## Interface
- NUM_REQ, 4, number of requesters, 2..8
- DATA_W, 8, signed sample width, Q4.4 fixed, not to be changed
- FRAC_W, 4, fractional bits of a sample; table index width = DATA_W-FRAC_W
- ID_W, 2, ceil(log2(NUM_REQ))

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request
- req_data  in  NUM_REQ*8  packed; requester i at [8i+7:8i], signed Q4.4
- req_ready  out  NUM_REQ  one-hot grant pulse; request accepted this cycle
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  8  signed Q4.4 interpolated value
- out_id  out  ID_W  index of the requester that issued the sample
- cfg_we  in  1  table write strobe
- cfg_addr  in  4  table entry
- cfg_data  in  8  signed breakpoint value
- cfg_ready  out  1  high only in IDLE; writes are ignored otherwise
- busy  out  1  high in any state other than IDLE

## Operation
- FSM: IDLE -> FETCH -> CALC -> OUT -> IDLE.
- IDLE: if cfg_we, write lut[cfg_addr] <= cfg_data; no grant that cycle (config has priority). Otherwise, if any req_valid, grant the first valid requester searching from last_grant+1 (mod NUM_REQ), pulse req_ready for one cycle, latch sample x and id, update last_grant, go to FETCH.
- FETCH: idx = x[7:4] + 8 (unsigned 0..15, -8 maps to 0); rem = x[3:0] unsigned. Register base = lut[idx]; next = lut[idx+1] when idx < 15, else next = base.
- CALC: diff = next - base as 9-bit signed; prod = diff * {0,rem} as 14-bit signed; result = base + (prod >>> 4), arithmetic shift. The result always lies between base and next, so the 8-bit truncation is exact and no saturation is needed. Register the result.
- OUT: out_valid high with out_data and out_id stable until out_ready. Transfer happens when out_valid && out_ready, then the FSM returns to IDLE.
- Only one sample is in flight; req_ready stays low outside IDLE.
- cfg_we outside IDLE is dropped silently; the table is unchanged.

## Timing
- Reset (rst low, async): state IDLE, all lut entries 0, last_grant = NUM_REQ-1 (requester 0 wins first), out_valid 0, out_data 0, out_id 0, req_ready 0, busy 0, cfg_ready 1 after release.
- Latency: grant at cycle T, out_valid at T+3. With out_ready held high the next grant is at T+4, so sustained throughput is one result per 4 cycles.
- Backpressure: out_ready low holds the FSM in OUT; the outputs do not change.
- A requester deasserting req_valid before grant loses nothing; the arbiter only samples valid in IDLE.
- Reset asserted mid-operation aborts the in-flight sample. No response is produced and the table is cleared.

## Test plan
- Identity table, lut[i] = (i-8)*16. Send 0x18 on requester 0 -> out_data 0x18, out_id 0, out_valid exactly 3 cycles after the req_ready pulse.
- Top-edge clamp, same table. Send 0x7F -> idx 15, next = base = 0x70, out_data 0x70.
- Extreme slope: lut[3] = 0x80, lut[4] = 0x7F, x = 0xBF (idx 3, rem 15) -> diff 255, out_data 0x6F (111), no overflow.
- Fairness: all four req_valid held high, out_ready high -> grants in order 0,1,2,3,0 spaced 4 cycles apart, out_id matches each grant.
- Backpressure and config: hold out_ready low 10 cycles with a result pending -> out_data and out_id stable, cfg_ready 0, and a cfg_we in this window leaves the table unchanged. Then assert cfg_we together with req_valid in IDLE -> write lands, grant is delayed one cycle.
- Reset mid-operation: drop rst in CALC -> out_valid 0 immediately. After release the table reads 0, so a new request returns 0x00 and requester 0 wins first.
